// File: rtl/udp_rx_buffer_pkg.sv
// Shared types and helpers for the UDP receive store-and-forward buffer.
// Holds the write-state encoding, entry width and pointer arithmetic.
package udp_rx_buffer_pkg;

    typedef enum logic {
        WR_STORE = 1'b0,
        WR_DROP  = 1'b1
    } wr_state_e;

    localparam int ENTRY_W = 9;

    // Modulo-2^pw difference of two zero-extended pointers.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned pw
    );
        logic [31:0] mask;
        mask = (32'h1 << pw) - 32'h1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/udp_rx_buffer_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// The read register doubles as the user-side output register.
module sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value unless a read is enabled.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read register, cleared by reset so outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/udp_rx_buffer.sv
// Store-and-forward UDP payload buffer: packets are released only once
// complete; packets that do not fit are discarded whole and counted.
module udp_rx_buffer
    import udp_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      logic_clk,
    input  logic                      logic_rst,
    input  logic [7:0]                udp_rdata_in,
    input  logic                      udp_rvalid_in,
    output logic                      udp_rready_out,
    input  logic                      udp_rlast_in,
    output logic [7:0]                user_rdata_out,
    output logic                      user_rvalid_out,
    input  logic                      user_rready_in,
    output logic                      user_rlast_out,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_out,
    output logic [ADDR_WIDTH:0]       pkt_cnt_out
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0]             PTR_ONE  = PW'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

    wr_state_e                 state_q, state_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                      vld_q, vld_d;
    logic                      rdy_q, rdy_d;
    logic [PW-1:0]             pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic               accept;
    logic               full;
    logic [31:0]        used;
    logic               readable;
    logic               commit;
    logic               drop_inc;
    logic               pop;
    logic               ram_we;
    logic               ram_re;
    logic [ENTRY_W-1:0] ram_rdata;

    assign accept   = udp_rvalid_in && rdy_q;
    assign used     = ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW);
    assign full     = (used == 32'(DEPTH));
    assign readable = (rd_ptr_q != commit_ptr_q);
    assign pop      = vld_q && user_rready_in && ram_rdata[8];
    assign rdy_d    = 1'b1;

    // Write FSM: store beats speculatively, commit on last, drop on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ram_we       = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        if (accept) begin
            unique case (state_q)
                WR_STORE: begin
                    if (!full) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (udp_rlast_in) begin
                            commit_ptr_d = wr_ptr_q + PTR_ONE;
                            commit       = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        if (udp_rlast_in) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d = WR_DROP;
                        end
                    end
                end
                WR_DROP: begin
                    if (udp_rlast_in) begin
                        drop_inc = 1'b1;
                        state_d  = WR_STORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read side: refill the output register whenever it is free or taken.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        ram_re   = 1'b0;
        if (!vld_q || user_rready_in) begin
            if (readable) begin
                ram_re   = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                vld_d    = 1'b1;
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    // Packet and saturating drop counters.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (commit && !pop) begin
            pkt_cnt_d = pkt_cnt_q + PTR_ONE;
        end else if (pop && !commit) begin
            pkt_cnt_d = pkt_cnt_q - PTR_ONE;
        end
        if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_ONE;
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_q      <= WR_STORE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            vld_q        <= 1'b0;
            rdy_q        <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            vld_q        <= vld_d;
            rdy_q        <= rdy_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    sdp_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk   (logic_clk),
        .rst   (logic_rst),
        .we    (ram_we),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata ({udp_rlast_in, udp_rdata_in}),
        .re    (ram_re),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    assign udp_rready_out  = rdy_q;
    assign user_rdata_out  = ram_rdata[7:0];
    assign user_rlast_out  = ram_rdata[8];
    assign user_rvalid_out = vld_q;
    assign drop_cnt_out    = drop_cnt_q;
    assign pkt_cnt_out     = pkt_cnt_q;

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Directed bench for udp_rx_buffer: a full-size instance and a small
// 64-byte instance with a 2-bit drop counter for overflow cases.
module tb_udp_rx_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst;
    logic [7:0]  a_din;
    logic        a_vin;
    logic        a_rdy;
    logic        a_lin;
    logic [7:0]  a_dout;
    logic        a_vout;
    logic        a_uready;
    logic        a_lout;
    logic [15:0] a_drop;
    logic [11:0] a_pkt;

    logic        b_rst;
    logic [7:0]  b_din;
    logic        b_vin;
    logic        b_rdy;
    logic        b_lin;
    logic [7:0]  b_dout;
    logic        b_vout;
    logic        b_uready;
    logic        b_lout;
    logic [1:0]  b_drop;
    logic [6:0]  b_pkt;

    udp_rx_buffer u_a (
        .logic_clk       (clk),
        .logic_rst       (a_rst),
        .udp_rdata_in    (a_din),
        .udp_rvalid_in   (a_vin),
        .udp_rready_out  (a_rdy),
        .udp_rlast_in    (a_lin),
        .user_rdata_out  (a_dout),
        .user_rvalid_out (a_vout),
        .user_rready_in  (a_uready),
        .user_rlast_out  (a_lout),
        .drop_cnt_out    (a_drop),
        .pkt_cnt_out     (a_pkt)
    );

    udp_rx_buffer #(
        .ADDR_WIDTH     (6),
        .DROP_CNT_WIDTH (2)
    ) u_b (
        .logic_clk       (clk),
        .logic_rst       (b_rst),
        .udp_rdata_in    (b_din),
        .udp_rvalid_in   (b_vin),
        .udp_rready_out  (b_rdy),
        .udp_rlast_in    (b_lin),
        .user_rdata_out  (b_dout),
        .user_rvalid_out (b_vout),
        .user_rready_in  (b_uready),
        .user_rlast_out  (b_lout),
        .drop_cnt_out    (b_drop),
        .pkt_cnt_out     (b_pkt)
    );

    task automatic send_a(input int len, input int base);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            a_din = 8'(base + i);
            a_vin = 1'b1;
            a_lin = (i == len - 1);
        end
        @(negedge clk);
        a_vin = 1'b0;
        a_lin = 1'b0;
    endtask

    task automatic send_b(input int len, input int base);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            b_din = 8'(base + i);
            b_vin = 1'b1;
            b_lin = (i == len - 1);
        end
        @(negedge clk);
        b_vin = 1'b0;
        b_lin = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        b_rst = 1'b1;
        b_vin = 1'b0;
        b_lin = 1'b0;
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_din = '0; a_vin = 1'b0; a_lin = 1'b0; a_uready = 1'b0;
        b_rst = 1'b1; b_din = '0; b_vin = 1'b0; b_lin = 1'b0; b_uready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_rdy, a_vout, a_dout, a_lout, a_drop, a_pkt} !== '0) begin
            errors++;
            $display("FAIL reset_a_outputs got rdy=%b vld=%b pkt=%0d want all 0",
                     a_rdy, a_vout, a_pkt);
        end
        checks++;
        if ({b_rdy, b_vout, b_dout, b_lout, b_drop, b_pkt} !== '0) begin
            errors++;
            $display("FAIL reset_b_outputs got rdy=%b vld=%b pkt=%0d want all 0",
                     b_rdy, b_vout, b_pkt);
        end
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rready_after_reset got a=%b b=%b want 1 1", a_rdy, b_rdy);
        end
    endtask

    task automatic test_single();
        int got;
        int first;
        a_uready = 1'b1;
        send_a(10, 0);
        checks++;
        if (a_vout !== 1'b0 || a_pkt !== 12'd1) begin
            errors++;
            $display("FAIL single_commit got vld=%b pkt=%0d want vld=0 pkt=1",
                     a_vout, a_pkt);
        end
        got = 0;
        first = -1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (a_vout) begin
                if (first < 0) first = c;
                checks++;
                if (a_dout !== 8'(got) || a_lout !== (got == 9)) begin
                    errors++;
                    $display("FAIL single_byte%0d got %h/%b want %h/%b",
                             got, a_dout, a_lout, 8'(got), (got == 9));
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 10 || first !== 1) begin
            errors++;
            $display("FAIL single_count got %0d bytes first@%0d want 10 first@1",
                     got, first);
        end
        checks++;
        if (a_pkt !== 12'd0 || a_vout !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got pkt=%0d vld=%b want 0 0", a_pkt, a_vout);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        int lens[3];
        int got;
        lens[0] = 1;
        lens[1] = 64;
        lens[2] = 1472;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < lens[p]; i++) begin
                exp_q.push_back({(i == lens[p] - 1), 8'(p * 50 + i * 7)});
            end
        end
        got = 0;
        fork
            begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    @(negedge clk);
                    a_din = exp_q[k][7:0];
                    a_lin = exp_q[k][8];
                    a_vin = 1'b1;
                end
                @(negedge clk);
                a_vin = 1'b0;
                a_lin = 1'b0;
            end
            begin
                for (int c = 0; c < 6000 && got < exp_q.size(); c++) begin
                    @(negedge clk);
                    a_uready = 1'($urandom_range(0, 1));
                    if (a_vout && a_uready) begin
                        checks++;
                        if ({a_lout, a_dout} !== exp_q[got]) begin
                            errors++;
                            $display("FAIL b2b_byte%0d got %h want %h",
                                     got, {a_lout, a_dout}, exp_q[got]);
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge clk);
        a_uready = 1'b1;
        checks++;
        if (got !== 1537 || a_drop !== 16'd0 || a_pkt !== 12'd0) begin
            errors++;
            $display("FAIL b2b_totals got n=%0d drop=%0d pkt=%0d want 1537 0 0",
                     got, a_drop, a_pkt);
        end
    endtask

    task automatic test_drop();
        int got;
        reset_b();
        b_uready = 1'b0;
        send_b(40, 0);
        send_b(30, 100);
        checks++;
        if (b_drop !== 2'd1 || b_pkt !== 7'd1) begin
            errors++;
            $display("FAIL drop_second got drop=%0d pkt=%0d want 1 1", b_drop, b_pkt);
        end
        b_uready = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 40; c++) begin
            if (b_vout) begin
                checks++;
                if (b_dout !== 8'(got) || b_lout !== (got == 39)) begin
                    errors++;
                    $display("FAIL drop_read%0d got %h/%b want %h/%b",
                             got, b_dout, b_lout, 8'(got), (got == 39));
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 40 || b_pkt !== 7'd0 || b_vout !== 1'b0) begin
            errors++;
            $display("FAIL drop_drain got n=%0d pkt=%0d vld=%b want 40 0 0",
                     got, b_pkt, b_vout);
        end
    endtask

    task automatic test_exact_full();
        int got;
        b_uready = 1'b0;
        send_b(64, 8'h40);
        send_b(65, 8'h80);
        checks++;
        if (b_drop !== 2'd2 || b_pkt !== 7'd1) begin
            errors++;
            $display("FAIL full_store got drop=%0d pkt=%0d want 2 1", b_drop, b_pkt);
        end
        b_uready = 1'b1;
        got = 0;
        for (int c = 0; c < 300 && got < 64; c++) begin
            if (b_vout) begin
                checks++;
                if (b_dout !== 8'(8'h40 + got) || b_lout !== (got == 63)) begin
                    errors++;
                    $display("FAIL full_read%0d got %h/%b want %h/%b",
                             got, b_dout, b_lout, 8'(8'h40 + got), (got == 63));
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 64 || b_pkt !== 7'd0) begin
            errors++;
            $display("FAIL full_drain got n=%0d pkt=%0d want 64 0", got, b_pkt);
        end
        send_b(65, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (b_drop !== 2'd3 || b_pkt !== 7'd0 || b_vout !== 1'b0) begin
            errors++;
            $display("FAIL oversize_ready got drop=%0d pkt=%0d vld=%b want 3 0 0",
                     b_drop, b_pkt, b_vout);
        end
    endtask

    task automatic test_mid_reset();
        int got;
        a_uready = 1'b0;
        send_a(8, 8'h10);
        send_a(8, 8'h20);
        checks++;
        if (a_pkt !== 12'd2 || a_vout !== 1'b1 || a_dout !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset got pkt=%0d vld=%b data=%h want 2 1 10",
                     a_pkt, a_vout, a_dout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_din = 8'(8'h30 + i);
            a_vin = 1'b1;
            a_lin = 1'b0;
        end
        @(negedge clk);
        a_rst = 1'b1;
        a_vin = 1'b0;
        #1;
        checks++;
        if ({a_rdy, a_vout, a_dout, a_lout, a_drop, a_pkt} !== '0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b vld=%b data=%h pkt=%0d want all 0",
                     a_rdy, a_vout, a_dout, a_pkt);
        end
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        repeat (2) @(negedge clk);
        a_uready = 1'b1;
        send_a(5, 8'hA0);
        checks++;
        if (a_pkt !== 12'd1 || a_drop !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_cnt got pkt=%0d drop=%0d want 1 0", a_pkt, a_drop);
        end
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (a_vout) begin
                checks++;
                if (a_dout !== 8'(8'hA0 + got) || a_lout !== (got == 4)) begin
                    errors++;
                    $display("FAIL post_reset_byte%0d got %h/%b want %h/%b",
                             got, a_dout, a_lout, 8'(8'hA0 + got), (got == 4));
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 5 || a_pkt !== 12'd0) begin
            errors++;
            $display("FAIL post_reset_drain got n=%0d pkt=%0d want 5 0", got, a_pkt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp;
        reset_b();
        b_uready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_b(65, k);
            exp = (k < 3) ? 2'(k + 1) : 2'd3;
            checks++;
            if (b_drop !== exp || b_pkt !== 7'd0) begin
                errors++;
                $display("FAIL saturate%0d got drop=%0d pkt=%0d want %0d 0",
                         k, b_drop, b_pkt, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_exact_full();
        test_mid_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
